fetch_decode_queue: RTL and testbench

Dual-issue instruction queue between `fetch_unit` and decode. Accepts up to two instructions per cycle from fetch, stores them in order with their PCs, and presents the two oldest entries to decode, which consumes 0, 1 or 2 per cycle. Drives the `stall` input of `fetch_unit` when it cannot absorb another pair. Flushes on a taken branch.

---
 rtl/fetch_decode_queue.sv | 133 +++++++++++++
 tb/tb_fetch_decode_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: dual-issue instruction queue between fetch and decode.
// Accepts up to two instructions per cycle, presents the two oldest to decode.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush               : taken-branch flush, empties the queue
//   in_valid            : fetch presents a pair this cycle
//   in_instr1/in_instr2 : older / younger instruction of the pair
//   in_pc               : PC of in_instr1 (in_instr2 is at in_pc+4)
//   stall               : queue cannot absorb another pair
//   dec_take            : head entries consumed by decode (3 acts as 2)
//   out_valid1/2        : head / second entry valid
//   out_instr1/2        : head / second instruction, 0 when invalid
//   out_pc1/2           : head / second PC, 0 when invalid
//   count               : occupied entries
module fetch_decode_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_instr1,
    input  logic [XLEN-1:0]          in_instr2,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     stall,
    input  logic [1:0]               dec_take,
    output logic                     out_valid1,
    output logic                     out_valid2,
    output logic [XLEN-1:0]          out_instr1,
    output logic [XLEN-1:0]          out_instr2,
    output logic [XLEN-1:0]          out_pc1,
    output logic [XLEN-1:0]          out_pc2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage is never cleared; validity comes from count_q alone.
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] instr_d [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq;
    logic [CW-1:0] take;
    logic [CW-1:0] deq;
    logic [PW-1:0] tail_p1;
    logic [PW-1:0] head_p1;

    // Stall looks only at the registered count; a same-cycle dequeue
    // is not credited, which keeps this path short.
    assign stall = (count_q > CW'(DEPTH - 2));

    assign enq     = in_valid && !stall && !flush;
    assign tail_p1 = tail_q + PW'(1);
    assign head_p1 = head_q + PW'(1);

    always_comb begin
        take = '0;
        unique case (dec_take)
            2'd0:    take = CW'(0);
            2'd1:    take = CW'(1);
            default: take = CW'(2);
        endcase
    end

    // Over-request simply drains what is there.
    assign deq = (take > count_q) ? count_q : take;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (enq) begin
            instr_d[tail_q]  = in_instr1;
            pc_d[tail_q]     = in_pc;
            instr_d[tail_p1] = in_instr2;
            pc_d[tail_p1]    = in_pc + XLEN'(4);
        end
    end

    // Flush outranks both enqueue and dequeue in the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d = head_q + deq[PW-1:0];
            if (enq) begin
                tail_d = tail_q + PW'(2);
            end
            count_d = count_q + (enq ? CW'(2) : CW'(0)) - deq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign out_valid1 = (count_q >= CW'(1));
    assign out_valid2 = (count_q >= CW'(2));

    assign out_instr1 = out_valid1 ? instr_q[head_q]  : '0;
    assign out_pc1    = out_valid1 ? pc_q[head_q]     : '0;
    assign out_instr2 = out_valid2 ? instr_q[head_p1] : '0;
    assign out_pc2    = out_valid2 ? pc_q[head_p1]    : '0;

    assign count = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed and randomized checks of the
// instruction queue against a queue-based reference model.
module tb_fetch_decode_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_instr1;
    logic [XLEN-1:0] in_instr2;
    logic [XLEN-1:0] in_pc;
    logic            stall;
    logic [1:0]      dec_take;
    logic            out_valid1;
    logic            out_valid2;
    logic [XLEN-1:0] out_instr1;
    logic [XLEN-1:0] out_instr2;
    logic [XLEN-1:0] out_pc1;
    logic [XLEN-1:0] out_pc2;
    logic [3:0]      count;

    int nchecks = 0;
    int nerrors = 0;

    // Model: each element is {pc, instr}, index 0 is the oldest.
    logic [63:0] mq[$];

    fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr1  (in_instr1),
        .in_instr2  (in_instr2),
        .in_pc      (in_pc),
        .stall      (stall),
        .dec_take   (dec_take),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_instr1 (out_instr1),
        .out_instr2 (out_instr2),
        .out_pc1    (out_pc1),
        .out_pc2    (out_pc2),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the applied inputs.
    task automatic model_edge();
        int n;
        int t;
        bit full;
        if (reset || flush) begin
            mq.delete();
        end else begin
            n    = mq.size();
            full = (n > DEPTH - 2);
            t    = (dec_take == 2'd0) ? 0 : (dec_take == 2'd1) ? 1 : 2;
            if (t > n) t = n;
            for (int i = 0; i < t; i++) void'(mq.pop_front());
            if (in_valid && !full) begin
                mq.push_back({in_pc, in_instr1});
                mq.push_back({in_pc + 32'd4, in_instr2});
            end
        end
    endtask

    task automatic compare_all();
        int n;
        logic [63:0] e1;
        logic [63:0] e2;
        n  = mq.size();
        e1 = (n >= 1) ? mq[0] : 64'd0;
        e2 = (n >= 2) ? mq[1] : 64'd0;
        chk("count", 64'(count), 64'(n));
        chk("stall", 64'(stall), 64'(n > DEPTH - 2));
        chk("out_valid1", 64'(out_valid1), 64'(n >= 1));
        chk("out_valid2", 64'(out_valid2), 64'(n >= 2));
        chk("out_instr1", 64'(out_instr1), 64'(e1[31:0]));
        chk("out_pc1", 64'(out_pc1), 64'(e1[63:32]));
        chk("out_instr2", 64'(out_instr2), 64'(e2[31:0]));
        chk("out_pc2", 64'(out_pc2), 64'(e2[63:32]));
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [1:0] tk, input logic [31:0] i1,
                        input logic [31:0] i2, input logic [31:0] pc);
        reset     = r;
        flush     = f;
        in_valid  = v;
        dec_take  = tk;
        in_instr1 = i1;
        in_instr2 = i2;
        in_pc     = pc;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; dec_take = 2'd0;
        in_instr1 = '0; in_instr2 = '0; in_pc = '0;

        // Reset with fetch active.
        step(1, 0, 1, 0, 32'h1, 32'h2, 32'h40);
        step(1, 0, 1, 0, 32'h1, 32'h2, 32'h40);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'({out_valid1, out_valid2}), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_outs", 64'(out_instr1 | out_instr2 | out_pc1 | out_pc2),
            64'd0);

        // Single pair.
        step(0, 0, 1, 0, 32'h11, 32'h22, 32'h100);
        chk("sp_i1", 64'(out_instr1), 64'h11);
        chk("sp_pc1", 64'(out_pc1), 64'h100);
        chk("sp_i2", 64'(out_instr2), 64'h22);
        chk("sp_pc2", 64'(out_pc2), 64'h104);
        chk("sp_count", 64'(count), 64'd2);

        // Fill to DEPTH.
        step(0, 0, 1, 0, 32'h33, 32'h44, 32'h108);
        step(0, 0, 1, 0, 32'h55, 32'h66, 32'h110);
        step(0, 0, 1, 0, 32'h77, 32'h88, 32'h118);
        chk("full_count", 64'(count), 64'd8);
        chk("full_stall", 64'(stall), 64'd1);
        step(0, 0, 1, 0, 32'h99, 32'h9A, 32'h120);
        chk("drop_count", 64'(count), 64'd8);
        step(0, 0, 0, 2, 32'h0, 32'h0, 32'h0);
        chk("drain_count", 64'(count), 64'd6);
        chk("drain_stall", 64'(stall), 64'd0);
        chk("drain_head", 64'(out_instr1), 64'h33);

        // Flush beats enqueue and dequeue.
        step(0, 1, 1, 2, 32'hE1, 32'hE2, 32'h200);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'({out_valid1, out_valid2}), 64'd0);
        step(0, 0, 1, 0, 32'hAA, 32'hBB, 32'h5);
        chk("redir_i1", 64'(out_instr1), 64'hAA);
        chk("redir_pc1", 64'(out_pc1), 64'h5);
        chk("redir_pc2", 64'(out_pc2), 64'h9);

        // Partial and over-consumption.
        step(0, 0, 1, 0, 32'hCC, 32'hDD, 32'h20);
        step(0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        chk("part_count", 64'(count), 64'd3);
        chk("part_head", 64'(out_instr1), 64'hBB);
        step(0, 0, 0, 2, 32'h0, 32'h0, 32'h0);
        chk("one_head", 64'(out_instr1), 64'hDD);
        step(0, 0, 0, 2, 32'h0, 32'h0, 32'h0);
        chk("over_count", 64'(count), 64'd0);
        chk("over_valid1", 64'(out_valid1), 64'd0);

        // Simultaneous enqueue/dequeue around the wrap point.
        for (int k = 0; k < 6; k++)
            step(0, 0, 1, 2, 32'h300 + 32'(k), 32'h400 + 32'(k),
                 32'h1000 + 32'(8 * k));

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7),
                 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom & 32'hFFFF_FFFC);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
